// File: rtl/wb_ana_cevirici_pkg.sv
// Shared types and constants for the Wishbone B4 classic master.
// WB_ZAMANASIMI_EN adds the default timeout length used by the optional watchdog.
package wb_ana_cevirici_pkg;

  localparam int ADRES_GENISLIGI_BIT  = 32;
  localparam int SOZCUK_GENISLIGI_BIT = 32;

`ifdef WB_ZAMANASIMI_EN
  localparam int WB_ZAMANASIMI_DONGU = 256;
`endif

  typedef enum logic [1:0] {
    WB_BOSTA = 2'd0,
    WB_AKTIF = 2'd1,
    WB_TAMAM = 2'd2
  } wb_durum_e;

  typedef enum logic [1:0] {
    SONUC_YOK   = 2'd0,
    SONUC_ACK   = 2'd1,
    SONUC_ERR   = 2'd2,
    SONUC_ZAMAN = 2'd3
  } wb_sonuc_e;

  // Completion priority: ERR beats ACK, and any slave response beats watchdog expiry.
  function automatic wb_sonuc_e sonuc_coz(input logic aktif, input logic ack,
                                          input logic err, input logic doldu);
    wb_sonuc_e s;
    if (!aktif) begin
      s = SONUC_YOK;
    end else if (err) begin
      s = SONUC_ERR;
    end else if (ack) begin
      s = SONUC_ACK;
    end else if (doldu) begin
      s = SONUC_ZAMAN;
    end else begin
      s = SONUC_YOK;
    end
    return s;
  endfunction

endpackage

// File: rtl/wb_ana_cevirici_if.sv
// Request/ready handshake plus Wishbone bus signals of the peripheral bridge.
// master: the bridge's view; slave: requester + WB peripheral (testbench) view.
interface wb_ana_cevirici_if
  import wb_ana_cevirici_pkg::*;
#(
  parameter int AW = ADRES_GENISLIGI_BIT,
  parameter int DW = SOZCUK_GENISLIGI_BIT
);
  logic            istek_i;
  logic [AW-1:0]   adres_i;
  logic [DW-1:0]   veri_i;
  logic            yaz_i;
  logic [DW-1:0]   veri_o;
  logic            hazir_o;
  logic            hata_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    input  istek_i, adres_i, veri_i, yaz_i, wb_dat_i, wb_ack_i, wb_err_i,
    output veri_o, hazir_o, hata_o, wb_cyc_o, wb_stb_o, wb_we_o,
           wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output istek_i, adres_i, veri_i, yaz_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  veri_o, hazir_o, hata_o, wb_cyc_o, wb_stb_o, wb_we_o,
           wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_ana_cevirici_sayac.sv
// Watchdog counter for a Wishbone cycle left without ACK/ERR.
// Only built when WB_ZAMANASIMI_EN is defined.
`ifdef WB_ZAMANASIMI_EN
module wb_zamanasimi_sayaci #(
  parameter int DONGU = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic temizle_i,
  input  logic say_i,
  output logic doldu_o
);
  localparam int W = (DONGU > 1) ? $clog2(DONGU) : 1;
  localparam logic [W-1:0] SON = W'(DONGU - 1);

  logic [W-1:0] sayac_r;

  // Count idle cycles of the current bus cycle; cleared whenever no cycle is active.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_r <= {W{1'b0}};
    end else if (temizle_i) begin
      sayac_r <= {W{1'b0}};
    end else if (say_i) begin
      sayac_r <= sayac_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      sayac_r <= sayac_r;
    end
  end

  assign doldu_o = (sayac_r == SON);
endmodule
`endif

// File: rtl/wb_ana_cevirici.sv
// Wishbone B4 classic master: one registered request -> one WB cycle -> ready pulse.
// Define WB_ZAMANASIMI_EN to abort cycles that see no ACK/ERR within ZAMANASIMI_DONGU cycles.
module wb_ana_cevirici
  import wb_ana_cevirici_pkg::*;
#(
  parameter int ADRES_GENISLIGI  = ADRES_GENISLIGI_BIT,
  parameter int SOZCUK_GENISLIGI = SOZCUK_GENISLIGI_BIT
`ifdef WB_ZAMANASIMI_EN
  ,
  parameter int ZAMANASIMI_DONGU = WB_ZAMANASIMI_DONGU
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_ana_cevirici_if.master bus
);
  localparam int SEL_GENISLIGI = SOZCUK_GENISLIGI / 8;

  wb_durum_e durum_r;
  wb_durum_e durum_s;
  wb_sonuc_e sonuc_s;
  logic      aktif_s;
  logic      doldu_s;

  logic                        cyc_r,   cyc_s;
  logic                        we_r,    we_s;
  logic [ADRES_GENISLIGI-1:0]  adr_r,   adr_s;
  logic [SOZCUK_GENISLIGI-1:0] dat_r,   dat_s;
  logic [SEL_GENISLIGI-1:0]    sel_r,   sel_s;
  logic [SOZCUK_GENISLIGI-1:0] veri_r,  veri_s;
  logic                        hata_r,  hata_s;
  logic                        hazir_r, hazir_s;

  assign aktif_s = (durum_r == WB_AKTIF);

`ifdef WB_ZAMANASIMI_EN
  wb_zamanasimi_sayaci #(
    .DONGU (ZAMANASIMI_DONGU)
  ) u_sayac (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (!aktif_s),
    .say_i     (aktif_s && !bus.wb_ack_i && !bus.wb_err_i),
    .doldu_o   (doldu_s)
  );
`else
  assign doldu_s = 1'b0;
`endif

  // ACK/ERR outside AKTIF resolve to SONUC_YOK and are therefore ignored.
  assign sonuc_s = sonuc_coz(aktif_s, bus.wb_ack_i, bus.wb_err_i, doldu_s);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_r <= WB_BOSTA;
    end else begin
      durum_r <= durum_s;
    end
  end

  // Next-state logic; TAMAM always returns to BOSTA so no request is taken during it.
  always_comb begin
    durum_s = durum_r;
    case (durum_r)
      WB_BOSTA: begin
        if (bus.istek_i) begin
          durum_s = WB_AKTIF;
        end else begin
          durum_s = WB_BOSTA;
        end
      end
      WB_AKTIF: begin
        if (sonuc_s != SONUC_YOK) begin
          durum_s = WB_TAMAM;
        end else begin
          durum_s = WB_AKTIF;
        end
      end
      WB_TAMAM: durum_s = WB_BOSTA;
      default:  durum_s = WB_BOSTA;
    endcase
  end

  // Output logic: next values of every registered output.
  always_comb begin
    adr_s   = adr_r;
    dat_s   = dat_r;
    we_s    = we_r;
    veri_s  = veri_r;
    hata_s  = hata_r;
    hazir_s = 1'b0;

    if ((durum_r == WB_BOSTA) && bus.istek_i) begin
      adr_s = bus.adres_i;
      dat_s = bus.veri_i;
      we_s  = bus.yaz_i;
    end else begin
      adr_s = adr_r;
      dat_s = dat_r;
      we_s  = we_r;
    end

    case (sonuc_s)
      SONUC_ACK: begin
        veri_s  = we_r ? {SOZCUK_GENISLIGI{1'b0}} : bus.wb_dat_i;
        hata_s  = 1'b0;
        hazir_s = 1'b1;
      end
      SONUC_ERR, SONUC_ZAMAN: begin
        veri_s  = {SOZCUK_GENISLIGI{1'b0}};
        hata_s  = 1'b1;
        hazir_s = 1'b1;
      end
      default: begin
        veri_s  = veri_r;
        hata_s  = hata_r;
        hazir_s = 1'b0;
      end
    endcase

    cyc_s = (durum_s == WB_AKTIF);
    sel_s = cyc_s ? {SEL_GENISLIGI{1'b1}} : {SEL_GENISLIGI{1'b0}};
  end

  // Output registers; async reset drops CYC/STB at once and discards the pending completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= {ADRES_GENISLIGI{1'b0}};
      dat_r   <= {SOZCUK_GENISLIGI{1'b0}};
      sel_r   <= {SEL_GENISLIGI{1'b0}};
      veri_r  <= {SOZCUK_GENISLIGI{1'b0}};
      hata_r  <= 1'b0;
      hazir_r <= 1'b0;
    end else begin
      cyc_r   <= cyc_s;
      we_r    <= we_s;
      adr_r   <= adr_s;
      dat_r   <= dat_s;
      sel_r   <= sel_s;
      veri_r  <= veri_s;
      hata_r  <= hata_s;
      hazir_r <= hazir_s;
    end
  end

  assign bus.wb_cyc_o = cyc_r;
  assign bus.wb_stb_o = cyc_r;
  assign bus.wb_we_o  = we_r;
  assign bus.wb_adr_o = adr_r;
  assign bus.wb_dat_o = dat_r;
  assign bus.wb_sel_o = sel_r;
  assign bus.veri_o   = veri_r;
  assign bus.hata_o   = hata_r;
  assign bus.hazir_o  = hazir_r;

`ifdef SIM
  wb_ana_cevirici_denetci u_denetci (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .aktif_i(aktif_s),
    .ack_i  (bus.wb_ack_i),
    .err_i  (bus.wb_err_i)
  );
`endif
endmodule

`ifdef SIM
// Flags slaves that answer while no cycle is outstanding.
module wb_ana_cevirici_denetci (
  input logic clk_i,
  input logic rst_i,
  input logic aktif_i,
  input logic ack_i,
  input logic err_i
);
  yanit_yalniz_aktifte: assert property (
    @(posedge clk_i) disable iff (rst_i) (ack_i || err_i) |-> aktif_i
  );
endmodule
`endif

// File: tb/tb_wb_ana_cevirici.sv
// Self-checking bench for wb_ana_cevirici: vector table, scoreboard on hazir_o, reset and timeout sequences.
module tb_wb_ana_cevirici;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ana_cevirici_if #(.AW(32), .DW(32)) bus ();

`ifdef WB_ZAMANASIMI_EN
  wb_ana_cevirici #(.ADRES_GENISLIGI(32), .SOZCUK_GENISLIGI(32), .ZAMANASIMI_DONGU(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
`else
  wb_ana_cevirici #(.ADRES_GENISLIGI(32), .SOZCUK_GENISLIGI(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
`endif

  // tip: 0 = ACK, 1 = ERR, 2 = ACK+ERR together, 3 = slave silent
  typedef struct {
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [31:0] slave_veri;
    int          yanit;      // CYC cycle (1-based) in which the slave answers
    int          tip;
    logic [31:0] bek_veri;
    logic        bek_hata;
    bit          ardisik;    // presented in the hazir_o cycle of the previous transfer
  } vektor_t;

  typedef struct packed {
    logic [31:0] veri;
    logic        hata;
  } beklenen_t;

  vektor_t     tablo [8];
  beklenen_t   sb [$];
  int          toplam = 0;
  int          hatali = 0;
  logic [31:0] son_veri = 32'h0;
  logic        son_hata = 1'b0;

  task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hatali++;
      $display("FAIL %s: got %h expected %h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  // Scoreboard: every hazir_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    beklenen_t e;
    if (rst === 1'b0 && bus.hazir_o === 1'b1) begin
      toplam++;
      if (sb.size() == 0) begin
        hatali++;
        $display("FAIL sb_beklenmedik: hazir_o with no pending request, veri_o=%h hata_o=%b", bus.veri_o, bus.hata_o);
      end else begin
        e = sb.pop_front();
        if ({bus.veri_o, bus.hata_o} !== {e.veri, e.hata}) begin
          hatali++;
          $display("FAIL sb_sonuc: got veri_o=%h hata_o=%b expected veri_o=%h hata_o=%b",
                   bus.veri_o, bus.hata_o, e.veri, e.hata);
        end
      end
    end
  end

  // Drives one request from a negedge and plays the slave until hazir_o is seen.
  task automatic islem(input vektor_t v);
    int n, cyc_len, ilk_cyc, hazir_n;
    beklenen_t b;
    bus.istek_i  = 1'b1;
    bus.adres_i  = v.adres;
    bus.veri_i   = v.veri;
    bus.yaz_i    = v.yaz;
    bus.wb_dat_i = v.slave_veri;
    b.veri = v.bek_veri;
    b.hata = v.bek_hata;
    sb.push_back(b);
    n = 0; cyc_len = 0; ilk_cyc = -1; hazir_n = -1;
    while (hazir_n < 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        kontrol("hazir_tek_darbe", {63'd0, bus.hazir_o}, 64'd0);
        kontrol("sonuc_tutma", {31'd0, bus.veri_o, bus.hata_o}, {31'd0, son_veri, son_hata});
      end
      if (bus.wb_cyc_o) begin
        cyc_len++;
        if (cyc_len == 1) begin
          ilk_cyc = n;
          kontrol("wb_adr", {32'd0, bus.wb_adr_o}, {32'd0, v.adres});
          kontrol("wb_we_dat", {31'd0, bus.wb_we_o, bus.wb_dat_o}, {31'd0, v.yaz, v.veri});
          kontrol("wb_stb_sel", {59'd0, bus.wb_stb_o, bus.wb_sel_o}, 64'h1F);
          bus.adres_i = ~v.adres;
          bus.veri_i  = ~v.veri;
          bus.yaz_i   = ~v.yaz;
        end else begin
          kontrol("wb_kararli", {bus.wb_adr_o, bus.wb_dat_o}, {v.adres, v.veri});
        end
        if (v.tip != 3 && cyc_len == v.yanit) begin
          bus.wb_ack_i = (v.tip != 1);
          bus.wb_err_i = (v.tip != 0);
        end
      end else if (bus.hazir_o) begin
        hazir_n = n;
      end
    end
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.istek_i  = 1'b0;
    kontrol("cyc_gecikme", 64'(ilk_cyc), v.ardisik ? 64'd2 : 64'd1);
    kontrol("cyc_suresi", 64'(cyc_len), 64'(v.yanit));
    kontrol("hazir_gecikme", 64'(hazir_n), 64'(ilk_cyc + v.yanit));
    son_veri = v.bek_veri;
    son_hata = v.bek_hata;
  endtask

  initial begin
    int      cnt;
    bit      hazir_gor;
    vektor_t v;

    bus.istek_i = 1'b0; bus.adres_i = 32'h0; bus.veri_i = 32'h0; bus.yaz_i = 1'b0;
    bus.wb_dat_i = 32'h0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

    // yaz, adres, veri, slave_veri, yanit, tip, bek_veri, bek_hata, ardisik
    tablo[0] = '{1'b0, 32'h2000_0004, 32'h0000_0000, 32'hCAFE_F00D, 3, 0, 32'hCAFE_F00D, 1'b0, 1'b0};
    tablo[1] = '{1'b1, 32'h2000_000C, 32'h0000_0041, 32'h7777_7777, 1, 0, 32'h0000_0000, 1'b0, 1'b0};
    tablo[2] = '{1'b0, 32'h2000_0008, 32'h0000_0000, 32'h1234_5678, 2, 2, 32'h0000_0000, 1'b1, 1'b0};
    tablo[3] = '{1'b0, 32'h2000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    tablo[4] = '{1'b1, 32'h2000_0014, 32'h1357_9BDF, 32'h0000_0000, 4, 1, 32'h0000_0000, 1'b1, 1'b0};
    tablo[5] = '{1'b0, 32'h2000_0018, 32'h0000_0000, 32'h0000_0001, 1, 0, 32'h0000_0001, 1'b0, 1'b1};
    tablo[6] = '{1'b1, 32'h2000_001C, 32'hA5A5_5A5A, 32'h5555_5555, 2, 0, 32'h0000_0000, 1'b0, 1'b1};
    tablo[7] = '{1'b0, 32'h2000_0020, 32'h0000_0000, 32'hFFFF_FFFF, 5, 0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    kontrol("rst_wb_ctl", {57'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 64'd0);
    kontrol("rst_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 64'd0);
    kontrol("rst_sonuc", {30'd0, bus.veri_o, bus.hazir_o, bus.hata_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (!tablo[i].ardisik) @(negedge clk);
      islem(tablo[i]);
    end

    // Reset in the middle of a cycle: bus released at once, no completion.
    @(negedge clk);
    bus.istek_i = 1'b1; bus.adres_i = 32'h3000_0040; bus.yaz_i = 1'b0;
    repeat (2) @(negedge clk);
    kontrol("orta_cyc", {63'd0, bus.wb_cyc_o}, 64'd1);
    rst = 1'b1;
    bus.istek_i = 1'b0;
    #1;
    kontrol("orta_rst_cyc_stb", {62'd0, bus.wb_cyc_o, bus.wb_stb_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hazir_gor = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.hazir_o) hazir_gor = 1'b1;
    end
    kontrol("orta_hazir_yok", {63'd0, hazir_gor}, 64'd0);
    son_veri = 32'h0;
    son_hata = 1'b0;
    v = '{1'b0, 32'h2000_0028, 32'h0, 32'h0BAD_CAFE, 2, 0, 32'h0BAD_CAFE, 1'b0, 1'b0};
    islem(v);

    @(negedge clk);
`ifdef WB_ZAMANASIMI_EN
    v = '{1'b0, 32'h2000_0024, 32'h0, 32'h9999_9999, 16, 3, 32'h0000_0000, 1'b1, 1'b0};
    islem(v);
`else
    bus.istek_i = 1'b1; bus.adres_i = 32'h2000_0024; bus.yaz_i = 1'b0;
    cnt = 0;
    hazir_gor = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) cnt++;
      if (bus.hazir_o) hazir_gor = 1'b1;
    end
    kontrol("zamanasimi_yok_cyc", 64'(cnt), 64'd1000);
    kontrol("zamanasimi_yok_hazir", {63'd0, hazir_gor}, 64'd0);
    rst = 1'b1;
    bus.istek_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    kontrol("sb_bos_son", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", toplam, hatali);
    $finish;
  end

endmodule
